// File: rtl/program_sequencer.sv
// program_sequencer: program counter with increment, relative jump and a call/return stack.
// Define PROGRAM_SEQUENCER_STACK_EN to build the stack; without it CALL/RET are ignored.
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int OFS_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              jmp,
  input  logic [OFS_W-1:0]  jmp_offset,
  input  logic              call,
  input  logic [ADDR_W-1:0] call_target,
  input  logic              ret,
  output logic [ADDR_W-1:0] addr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
);
  logic [ADDR_W-1:0] inc, rel;
  assign inc = addr + ADDR_W'(1);
  assign rel = addr + ADDR_W'($signed(jmp_offset));
`ifdef PROGRAM_SEQUENCER_STACK_EN
  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [IDX_W-1:0]  top;
  logic              push;
  assign stack_full  = ptr == PTR_W'(STACK_DEPTH);
  assign stack_empty = ptr == '0;
  assign top         = IDX_W'(ptr - PTR_W'(1));
  assign push        = en && !ret && call && !stack_full;
  // entries are never read while empty, so they carry no reset
  always_ff @(posedge clk)
    if (push) stack[IDX_W'(ptr)] <= inc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      ptr  <= '0;
      err  <= 1'b0;
    end else if (en) begin
      if (ret && !stack_empty) begin
        addr <= stack[top];
        ptr  <= ptr - PTR_W'(1);
      end else if (ret || (call && stack_full)) begin
        addr <= inc;
        err  <= 1'b1;
      end else if (call) begin
        addr <= call_target;
        ptr  <= ptr + PTR_W'(1);
      end else addr <= jmp ? rel : inc;
    end
`else
  logic unused;
  assign unused      = ^{call, ret, call_target};
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign err         = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr <= '0;
    else if (en) addr <= jmp ? rel : inc;
`endif
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: randomized and directed checks of program_sequencer against a queue-based reference model.
module tb_program_sequencer;
`ifdef PROGRAM_SEQUENCER_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [3:0] jmp_offset = '0;
  logic [7:0] call_target = '0;
  logic [7:0] addr;
  logic       stack_full, stack_empty, err;
  int n_cmp = 0, n_bad = 0;
  int m_addr = 0;
  bit m_err = 1'b0;
  int q[$];

  program_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .jmp(jmp), .jmp_offset(jmp_offset),
    .call(call), .call_target(call_target), .ret(ret),
    .addr(addr), .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(bit e, bit j, logic [3:0] o, bit c, logic [7:0] t, bit r);
    int off;
    off = $signed(o);
    if (!e) return;
    if (STACK_EN && r) begin
      if (q.size() == 0) begin
        m_addr = (m_addr + 1) % 256;
        m_err = 1'b1;
      end else m_addr = q.pop_back();
    end else if (STACK_EN && c) begin
      if (q.size() == DEPTH) begin
        m_addr = (m_addr + 1) % 256;
        m_err = 1'b1;
      end else begin
        q.push_back((m_addr + 1) % 256);
        m_addr = int'(t);
      end
    end else if (j) m_addr = (m_addr + off + 256) % 256;
    else m_addr = (m_addr + 1) % 256;
  endfunction

  task automatic model_reset();
    m_addr = 0;
    m_err = 1'b0;
    q.delete();
  endtask

  task automatic step(input bit e, input bit j, input logic [3:0] o, input bit c,
                      input logic [7:0] t, input bit r);
    en = e; jmp = j; jmp_offset = o; call = c; call_target = t; ret = r;
    @(posedge clk);
    if (rst_n) model_edge(e, j, o, c, t, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic goto(input int target);
    int k = 0;
    while (m_addr != target && k < 300) begin
      step(1, 0, 4'd0, 0, 8'd0, 0);
      k++;
    end
    n_cmp++;
    if (addr !== 8'(target)) begin
      n_bad++;
      $display("FAIL goto: addr=%0d required=%0d", addr, target);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (addr !== 8'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: addr=%0d empty=%b full=%b err=%b required 0/1/0/0", addr, stack_empty, stack_full, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 4'd0, 0, 8'd0, 0);
      n_cmp++;
      if (addr !== 8'(m_addr)) begin
        n_bad++;
        $display("FAIL wrap[%0d]: addr=%0d required=%0d", i, addr, m_addr);
      end
    end
    n_cmp++;
    if (addr !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_end: addr=%0d required=0", addr);
    end
  endtask

  task automatic test_jump();
    goto(10);
    step(1, 1, 4'b1110, 0, 8'd0, 0);
    n_cmp++;
    if (addr !== 8'd8) begin
      n_bad++;
      $display("FAIL jmp_neg: addr=%0d required=8", addr);
    end
    step(1, 1, 4'b0000, 0, 8'd0, 0);
    n_cmp++;
    if (addr !== 8'd8) begin
      n_bad++;
      $display("FAIL jmp_zero: addr=%0d required=8", addr);
    end
    goto(1);
    step(1, 1, 4'b1110, 0, 8'd0, 0);
    n_cmp++;
    if (addr !== 8'd255) begin
      n_bad++;
      $display("FAIL jmp_wrap: addr=%0d required=255", addr);
    end
    step(1, 1, 4'b0111, 0, 8'd0, 0);
    n_cmp++;
    if (addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL jmp_pos: addr=%0d required=%0d", addr, m_addr);
    end
  endtask

  task automatic test_nested_calls();
    do_reset();
    goto(5);
    step(1, 0, 4'd0, 1, 8'h40, 0);
    n_cmp++;
    if (addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL call1: addr=%0d required=%0d", addr, m_addr);
    end
    if (STACK_EN) goto(8'h41);
    step(1, 0, 4'd0, 1, 8'h80, 0);
    n_cmp++;
    if (addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL call2: addr=%0d required=%0d", addr, m_addr);
    end
    step(1, 0, 4'd0, 0, 8'd0, 1);
    n_cmp++;
    if (addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL ret1: addr=%0d required=%0d", addr, m_addr);
    end
    step(1, 0, 4'd0, 0, 8'd0, 1);
    n_cmp++;
    if (addr !== 8'(m_addr) || stack_empty !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL ret2: addr=%0d empty=%b err=%b required %0d/1/0", addr, stack_empty, err, m_addr);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] a;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 4'd0, 1, 8'($urandom_range(0, 255)), 0);
    n_cmp++;
    if (stack_full !== (q.size() == DEPTH) || addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL fill: full=%b addr=%0d required %b/%0d", stack_full, addr, q.size() == DEPTH, m_addr);
    end
    a = 8'(m_addr);
    step(1, 0, 4'd0, 1, 8'($urandom_range(0, 255)), 0);
    n_cmp++;
    if (addr !== 8'(m_addr) || err !== m_err || (STACK_EN && addr !== a + 8'd1)) begin
      n_bad++;
      $display("FAIL overflow: addr=%0d err=%b required %0d/%b", addr, err, m_addr, m_err);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 4'd0, 0, 8'd0, 0);
    n_cmp++;
    if (err !== m_err || addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL err_sticky: err=%b addr=%0d required %b/%0d", err, addr, m_err, m_addr);
    end
  endtask

  task automatic test_underflow_priority();
    do_reset();
    goto(20);
    step(1, 1, 4'b0101, 1, 8'h33, 1);
    n_cmp++;
    if (addr !== 8'(m_addr) || err !== m_err) begin
      n_bad++;
      $display("FAIL underflow: addr=%0d err=%b required %0d/%b", addr, err, m_addr, m_err);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0011, 1, 8'h55, 1);
    n_cmp++;
    if (addr !== 8'(m_addr) || err !== m_err) begin
      n_bad++;
      $display("FAIL en_hold: addr=%0d err=%b required %0d/%b", addr, err, m_addr, m_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, 4'($urandom),
           $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 4) == 0);
      n_cmp++;
      if (addr !== 8'(m_addr) || err !== m_err || stack_empty !== (q.size() == 0) ||
          stack_full !== (STACK_EN && q.size() == DEPTH)) begin
        n_bad++;
        $display("FAIL random[%0d]: addr=%0d err=%b empty=%b full=%b required %0d/%b/%b/%b",
                 i, addr, err, stack_empty, stack_full, m_addr, m_err, q.size() == 0,
                 STACK_EN && q.size() == DEPTH);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    goto(9);
    step(1, 0, 4'd0, 1, 8'h70, 0);
    step(1, 0, 4'd0, 0, 8'd0, 1);
    step(1, 0, 4'd0, 0, 8'd0, 1);
    en = 1'b1; call = 1'b1; call_target = 8'h22;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (addr !== 8'd0 || stack_empty !== 1'b1 || err !== 1'b0 || stack_full !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: addr=%0d empty=%b err=%b full=%b required 0/1/0/0", addr, stack_empty, err, stack_full);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 4'd0, 0, 8'd0, 0);
    n_cmp++;
    if (addr !== 8'd1 || addr !== 8'(m_addr)) begin
      n_bad++;
      $display("FAIL resume: addr=%0d required=1", addr);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_jump();
    test_nested_calls();
    test_overflow();
    test_underflow_priority();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8: address width in bits, legal range 4..16.
REQ-002 The module SHALL have parameter OFS_W, default 4: signed relative-jump offset width, legal range 2..ADDR_W.
REQ-003 The module SHALL have parameter STACK_DEPTH, default 4: number of return-address entries, legal range 1..16.
REQ-004 The module SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port EN  input  1  advance enable; when low, all state holds.
REQ-007 The module SHALL have port JMP  input  1  relative jump request.
REQ-008 The module SHALL have port JMP_OFFSET  input  OFS_W  two's-complement offset applied to the current ADDR.
REQ-009 The module SHALL have port CALL  input  1  subroutine call request.
REQ-010 The module SHALL have port CALL_TARGET  input  ADDR_W  absolute call destination.
REQ-011 The module SHALL have port RET  input  1  return request.
REQ-012 The module SHALL have port ADDR  output  ADDR_W  current program address, registered.
REQ-013 The module SHALL have port STACK_FULL  output  1  high when STACK_DEPTH entries are held.
REQ-014 The module SHALL have port STACK_EMPTY  output  1  high when zero entries are held.
REQ-015 The module SHALL have port ERR  output  1  sticky stack-overflow/underflow flag.

Function
REQ-016 The module SHALL update ADDR, stack, and ERR only on a rising CLK edge with EN high; with EN low, all of them SHALL hold.
REQ-017 The module SHALL apply command priority RET > CALL > JMP > sequential increment; lower-priority requests in the same cycle SHALL be ignored.
REQ-018 On sequential increment, the module SHALL set ADDR to ADDR+1 modulo 2^ADDR_W (wrap from all-ones to 0).
REQ-019 On JMP, the module SHALL set ADDR to ADDR + sign_extend(JMP_OFFSET) modulo 2^ADDR_W, so an offset of 0 holds ADDR and negative offsets wrap below 0.
REQ-020 On CALL with the stack not full, the module SHALL push ADDR+1 (mod 2^ADDR_W) and set ADDR to CALL_TARGET in the same cycle.
REQ-021 On CALL with the stack full, the module SHALL perform no push, SHALL set ADDR to ADDR+1, and SHALL set ERR.
REQ-022 On RET with the stack not empty, the module SHALL pop the top entry into ADDR.
REQ-023 On RET with the stack empty, the module SHALL perform no pop, SHALL set ADDR to ADDR+1, and SHALL set ERR.
REQ-024 The stack SHALL be LIFO, and the module SHALL keep a pointer of ceil(log2(STACK_DEPTH+1)) bits.
REQ-025 The module SHALL decode STACK_FULL and STACK_EMPTY combinationally from the registered pointer, so they reflect the post-edge state with no extra latency.
REQ-026 Once set, ERR SHALL remain high until reset; further commands SHALL execute normally while ERR is high.
REQ-027 The module SHALL show a latency of exactly one clock from a command sampled high to the new ADDR.

Reset
REQ-028 While RST_N is low, the module SHALL force, asynchronously, ADDR=0, stack pointer=0, ERR=0, STACK_EMPTY=1, STACK_FULL=0.
REQ-029 Stack entry contents need not be cleared on reset, because they are unreadable while the stack is empty.
REQ-030 Reset asserted mid-call or mid-return SHALL discard the pending operation, and the module SHALL resume with ADDR=0 on the first enabled edge after RST_N rises.

Configuration
REQ-031 The call/return stack SHALL be controlled by macro PROGRAM_SEQUENCER_STACK_EN.
REQ-032 With PROGRAM_SEQUENCER_STACK_EN defined, the module SHALL behave per REQ-020..REQ-026.
REQ-033 Without PROGRAM_SEQUENCER_STACK_EN, the module SHALL implement no stack storage; CALL and RET SHALL be ignored (JMP/increment only); STACK_EMPTY SHALL be tied to 1, STACK_FULL to 0, and ERR to 0.

Verification
REQ-034 The bench SHALL cover wrap-around: defaults, EN=1, no commands, 256 cycles -> ADDR counts 0..255 then 0.
REQ-035 The bench SHALL cover relative jumps: ADDR=10, JMP with JMP_OFFSET=4'b1110 -> ADDR=8; then JMP with offset 0 -> ADDR stays 8; then ADDR=1 and offset -2 -> ADDR=255.
REQ-036 The bench SHALL cover nested calls: ADDR=5, CALL to 0x40, then CALL to 0x80 at 0x41, then RET twice -> ADDR 0x40, 0x80, 0x42, 6; STACK_EMPTY=1 at the end; ERR=0.
REQ-037 The bench SHALL cover overflow: four CALLs filling the stack (STACK_FULL=1), then a fifth CALL at ADDR=A -> ADDR=A+1 and ERR=1 held through later cycles.
REQ-038 The bench SHALL cover underflow and priority: empty stack, RET with CALL and JMP asserted at ADDR=20 -> ADDR=21 and ERR=1; EN=0 for 3 cycles -> ADDR holds 21.
REQ-039 The bench SHALL cover async reset: RST_N driven low between clock edges mid-sequence -> ADDR=0, STACK_EMPTY=1, ERR=0 immediately, with no clock edge required.
